// File: rtl/cmd_arbiter_pkg.sv
// Shared types and constants for the cmd_arbiter slice.
package kt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        EXEC,
        RESP
    } state_t;

    typedef enum logic {
        OWN_RMT,
        OWN_TC
    } owner_t;

    localparam logic [7:0] ACK_BYTE = 8'hA5;
    localparam logic [7:0] NAK_BYTE = 8'h5A;

    // Watchdog counter width: short for simulation builds, long for silicon.
    function automatic int unsigned wdog_width(input int unsigned fast_sim);
        return (fast_sim != 0) ? 16 : 26;
    endfunction

endpackage

// File: rtl/cmd_arbiter_if.sv
// Requester, cmd_proc and response signals of the command arbiter.
// slave: the arbiter's view. master: the surrounding system's view.
interface cmd_arbiter_if;

    logic [15:0] rmt_cmd;
    logic        rmt_cmd_rdy;
    logic        rmt_clr_cmd_rdy;
    logic [15:0] tc_cmd;
    logic        tc_cmd_rdy;
    logic        tc_clr_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        cp_clr_cmd_rdy;
    logic        cp_send_resp;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tc_done;
    logic        tc_nak;
    logic        owner;
    logic        busy;

    modport slave (
        input  rmt_cmd, rmt_cmd_rdy, tc_cmd, tc_cmd_rdy, cp_clr_cmd_rdy, cp_send_resp,
        output rmt_clr_cmd_rdy, tc_clr_cmd_rdy, cmd, cmd_rdy, tx_data, trmt,
               tc_done, tc_nak, owner, busy
    );

    modport master (
        output rmt_cmd, rmt_cmd_rdy, tc_cmd, tc_cmd_rdy, cp_clr_cmd_rdy, cp_send_resp,
        input  rmt_clr_cmd_rdy, tc_clr_cmd_rdy, cmd, cmd_rdy, tx_data, trmt,
               tc_done, tc_nak, owner, busy
    );

endinterface

// File: rtl/cmd_arbiter_wdog.sv
// Clear/enable watchdog counter. Stops at all ones; all ones is the timeout.
module cmd_wdog #(
    parameter int unsigned WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    logic [WIDTH-1:0] cnt_q;

    assign timeout = &cnt_q;

    // Count while enabled, hold at saturation, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !timeout) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cmd_arbiter.sv
// Two-requester command arbiter in front of cmd_proc.
// Optional macro CMD_ARB_RR_EN: round-robin tie breaking instead of
// fixed remote-over-tour priority.
module cmd_arbiter
    import kt_arb_pkg::*;
#(
    parameter int unsigned FAST_SIM = 1,
    parameter logic [7:0]  ACK      = ACK_BYTE,
    parameter logic [7:0]  NAK      = NAK_BYTE,
    // Derived from FAST_SIM; a narrower override only shortens the timeout.
    parameter int unsigned WDOG_W   = wdog_width(FAST_SIM)
) (
    input logic         clk,
    input logic         rst_n,
    cmd_arbiter_if.slave bus
);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        trmt_q, trmt_d;
    logic        tc_done_q, tc_done_d;
    logic        tc_nak_q, tc_nak_d;
    logic        rmt_clr_q, rmt_clr_d;
    logic        tc_clr_q, tc_clr_d;
    logic        busy_q, busy_d;

    logic wd_clr, wd_en, wd_timeout;
    logic any_req, pick_tc;
    logic resp_go, resp_nak;

    cmd_wdog #(
        .WIDTH(WDOG_W)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .timeout(wd_timeout)
    );

    assign any_req = bus.rmt_cmd_rdy | bus.tc_cmd_rdy;

`ifdef CMD_ARB_RR_EN
    owner_t last_owner_q;

    // A tie goes to whoever was not served last; a lone requester always wins.
    assign pick_tc = bus.tc_cmd_rdy & (~bus.rmt_cmd_rdy | (last_owner_q == OWN_RMT));

    // Remember the most recent grant; reset to tour so remote wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= OWN_TC;
        end else if (state_q == IDLE && any_req) begin
            last_owner_q <= pick_tc ? OWN_TC : OWN_RMT;
        end
    end
`else
    assign pick_tc = bus.tc_cmd_rdy & ~bus.rmt_cmd_rdy;
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        tx_data_d = tx_data_q;
        trmt_d    = 1'b0;
        tc_done_d = 1'b0;
        tc_nak_d  = 1'b0;
        rmt_clr_d = 1'b0;
        tc_clr_d  = 1'b0;
        wd_clr    = 1'b0;
        wd_en     = 1'b0;
        resp_go   = 1'b0;
        resp_nak  = 1'b0;

        unique case (state_q)
            IDLE: begin
                wd_clr = 1'b1;
                if (any_req) begin
                    state_d   = ISSUE;
                    owner_d   = pick_tc ? OWN_TC : OWN_RMT;
                    cmd_d     = pick_tc ? bus.tc_cmd : bus.rmt_cmd;
                    cmd_rdy_d = 1'b1;
                    rmt_clr_d = ~pick_tc;
                    tc_clr_d  = pick_tc;
                end
            end
            ISSUE: begin
                wd_en = 1'b1;
                if (wd_timeout) begin
                    cmd_rdy_d = 1'b0;
                    resp_go   = 1'b1;
                    resp_nak  = 1'b1;
                end else if (bus.cp_clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                wd_en = 1'b1;
                // Completion beats a simultaneous timeout.
                if (bus.cp_send_resp) begin
                    resp_go = 1'b1;
                end else if (wd_timeout) begin
                    resp_go  = 1'b1;
                    resp_nak = 1'b1;
                end
            end
            RESP: begin
                wd_clr  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (resp_go) begin
            state_d = RESP;
            if (owner_q == OWN_RMT) begin
                trmt_d    = 1'b1;
                tx_data_d = resp_nak ? NAK : ACK;
            end else begin
                tc_done_d = 1'b1;
                tc_nak_d  = resp_nak;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_RMT;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            tx_data_q <= '0;
            trmt_q    <= 1'b0;
            tc_done_q <= 1'b0;
            tc_nak_q  <= 1'b0;
            rmt_clr_q <= 1'b0;
            tc_clr_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            tx_data_q <= tx_data_d;
            trmt_q    <= trmt_d;
            tc_done_q <= tc_done_d;
            tc_nak_q  <= tc_nak_d;
            rmt_clr_q <= rmt_clr_d;
            tc_clr_q  <= tc_clr_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.cmd             = cmd_q;
    assign bus.cmd_rdy         = cmd_rdy_q;
    assign bus.owner           = owner_q;
    assign bus.tx_data         = tx_data_q;
    assign bus.trmt            = trmt_q;
    assign bus.tc_done         = tc_done_q;
    assign bus.tc_nak          = tc_nak_q;
    assign bus.rmt_clr_cmd_rdy = rmt_clr_q;
    assign bus.tc_clr_cmd_rdy  = tc_clr_q;
    assign bus.busy            = busy_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Bench for cmd_arbiter. The watchdog is narrowed to 8 bits so every
// timeout scenario completes in a few hundred cycles.
module tb_cmd_arbiter;

    localparam int WDW    = 8;
    localparam int WD_MAX = (1 << WDW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cmd_arbiter_if bus ();

    cmd_arbiter #(
        .WDOG_W(WDW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A grant is "open" from acceptance until its response; age counts the
    // cycles it has been open; the response occupies one extra busy cycle.
    logic [15:0] e_cmd;
    logic [7:0]  e_tx;
    logic        e_owner, e_rdy, e_rclr, e_tclr, e_trmt, e_done, e_nak, e_busy;
    bit          m_open, m_consumed, m_resp;
    int          m_age;
    logic        tour_wins, to_now, fin_now, fin_nak;

`ifdef CMD_ARB_RR_EN
    bit m_last;
    assign tour_wins = bus.tc_cmd_rdy && (!bus.rmt_cmd_rdy || !m_last);
`else
    assign tour_wins = bus.tc_cmd_rdy && !bus.rmt_cmd_rdy;
`endif
    assign to_now  = (m_age == WD_MAX);
    assign fin_now = m_open && (m_consumed ? (bus.cp_send_resp || to_now) : to_now);
    assign fin_nak = !(m_consumed && bus.cp_send_resp);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_cmd <= '0; e_tx <= '0; e_owner <= 0; e_rdy <= 0; e_rclr <= 0; e_tclr <= 0;
            e_trmt <= 0; e_done <= 0; e_nak <= 0; e_busy <= 0;
            m_open <= 0; m_consumed <= 0; m_resp <= 0; m_age <= 0;
`ifdef CMD_ARB_RR_EN
            m_last <= 1'b1;
`endif
        end else begin
            e_rclr <= 0; e_tclr <= 0; e_trmt <= 0; e_done <= 0; e_nak <= 0;
            if (m_resp) begin
                m_resp <= 0;
                e_busy <= 0;
            end else if (!m_open) begin
                if (bus.rmt_cmd_rdy || bus.tc_cmd_rdy) begin
                    e_cmd      <= tour_wins ? bus.tc_cmd : bus.rmt_cmd;
                    e_owner    <= tour_wins;
                    e_rdy      <= 1;
                    e_rclr     <= !tour_wins;
                    e_tclr     <= tour_wins;
                    e_busy     <= 1;
                    m_open     <= 1;
                    m_consumed <= 0;
                    m_age      <= 0;
`ifdef CMD_ARB_RR_EN
                    m_last     <= tour_wins;
`endif
                end
            end else begin
                m_age <= (m_age < WD_MAX) ? m_age + 1 : m_age;
                if (fin_now) begin
                    m_open <= 0;
                    m_resp <= 1;
                    e_rdy  <= 0;
                    if (!e_owner) begin
                        e_trmt <= 1;
                        e_tx   <= fin_nak ? 8'h5A : 8'hA5;
                    end else begin
                        e_done <= 1;
                        e_nak  <= fin_nak;
                    end
                end else if (!m_consumed && bus.cp_clr_cmd_rdy) begin
                    m_consumed <= 1;
                    e_rdy      <= 0;
                end
            end
        end
    end

    // Compare every output against the model shortly after each edge.
    always begin
        @(posedge clk);
        #1;
        chk("cmd", 32'(bus.cmd), 32'(e_cmd));
        chk("cmd_rdy", 32'(bus.cmd_rdy), 32'(e_rdy));
        chk("owner", 32'(bus.owner), 32'(e_owner));
        chk("tx_data", 32'(bus.tx_data), 32'(e_tx));
        chk("trmt", 32'(bus.trmt), 32'(e_trmt));
        chk("tc_done", 32'(bus.tc_done), 32'(e_done));
        chk("tc_nak", 32'(bus.tc_nak), 32'(e_nak));
        chk("rmt_clr", 32'(bus.rmt_clr_cmd_rdy), 32'(e_rclr));
        chk("tc_clr", 32'(bus.tc_clr_cmd_rdy), 32'(e_tclr));
        chk("busy", 32'(bus.busy), 32'(e_busy));
    end

    // ---------------- directed stimulus ----------------
    // sel: 0 rmt_clr, 1 tc_clr, 2 trmt, 3 tc_done, 5 either clr pulse
    task automatic wait_for(input int sel, input int max, output int n);
        bit hit = 0;
        n = 0;
        while (!hit && n < max) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = bus.rmt_clr_cmd_rdy;
                1:       hit = bus.tc_clr_cmd_rdy;
                2:       hit = bus.trmt;
                3:       hit = bus.tc_done;
                default: hit = bus.rmt_clr_cmd_rdy | bus.tc_clr_cmd_rdy;
            endcase
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_%0d: no event within %0d cycles", sel, max);
        end
    endtask

    // Called at a negedge inside ISSUE; returns at the negedge showing RESP.
    task automatic serve(input int delay);
        bus.cp_clr_cmd_rdy = 1;
        @(negedge clk);
        bus.cp_clr_cmd_rdy = 0;
        repeat (delay) @(negedge clk);
        bus.cp_send_resp = 1;
        @(negedge clk);
        bus.cp_send_resp = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  rr_tour;
        bus.rmt_cmd = '0; bus.rmt_cmd_rdy = 0; bus.tc_cmd = '0; bus.tc_cmd_rdy = 0;
        bus.cp_clr_cmd_rdy = 0; bus.cp_send_resp = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd", 32'(bus.cmd), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_owner", 32'(bus.owner), 0);
        chk("rst_tx", 32'(bus.tx_data), 0);
        rst_n = 1;
        @(negedge clk);

        // Remote only
        bus.rmt_cmd = 16'h4BF4; bus.rmt_cmd_rdy = 1;
        wait_for(0, 10, n);
        chk("t1_cmd", 32'(bus.cmd), 32'h4BF4);
        chk("t1_cmd_rdy", 32'(bus.cmd_rdy), 1);
        bus.rmt_cmd_rdy = 0;
        serve(100);
        chk("t1_trmt", 32'(bus.trmt), 1);
        chk("t1_tx", 32'(bus.tx_data), 32'hA5);
        @(negedge clk);
        chk("t1_busy", 32'(bus.busy), 0);

        // Tour only
        bus.tc_cmd = 16'h4002; bus.tc_cmd_rdy = 1;
        wait_for(1, 10, n);
        chk("t2_cmd", 32'(bus.cmd), 32'h4002);
        chk("t2_owner", 32'(bus.owner), 1);
        bus.tc_cmd_rdy = 0;
        serve(5);
        chk("t2_done", 32'(bus.tc_done), 1);
        chk("t2_nak", 32'(bus.tc_nak), 0);
        @(negedge clk);

        // Simultaneous requests; remote wins the first tie in both builds
        bus.rmt_cmd = 16'h4BF4; bus.tc_cmd = 16'h43F1;
        bus.rmt_cmd_rdy = 1; bus.tc_cmd_rdy = 1;
        wait_for(5, 10, n);
        chk("t3_first", 32'(bus.owner), 0);
        chk("t3_first_cmd", 32'(bus.cmd), 32'h4BF4);
        bus.rmt_cmd_rdy = 0;
        serve(3);
        bus.rmt_cmd_rdy = 1;
`ifdef CMD_ARB_RR_EN
        rr_tour = 1;
`else
        rr_tour = 0;
`endif
        wait_for(5, 10, n);
        chk("t3_second", 32'(bus.owner), 32'(rr_tour));
        if (rr_tour) bus.tc_cmd_rdy = 0; else bus.rmt_cmd_rdy = 0;
        serve(2);
        wait_for(5, 10, n);
        chk("t3_third", 32'(bus.owner), 32'(!rr_tour));
        bus.tc_cmd_rdy = 0; bus.rmt_cmd_rdy = 0;
        serve(2);
        @(negedge clk);

        // Remote timeout in EXEC: 255 cycles from consumption to trmt
        bus.rmt_cmd_rdy = 1;
        wait_for(0, 10, n);
        bus.rmt_cmd_rdy = 0;
        bus.cp_clr_cmd_rdy = 1;
        @(negedge clk);
        bus.cp_clr_cmd_rdy = 0;
        wait_for(2, WD_MAX + 10, n);
        chk("t4_cycles", 32'(n), 32'd255);
        chk("t4_tx", 32'(bus.tx_data), 32'h5A);
        @(negedge clk);

        // Tour timeout in EXEC
        bus.tc_cmd_rdy = 1;
        wait_for(1, 10, n);
        bus.tc_cmd_rdy = 0;
        bus.cp_clr_cmd_rdy = 1;
        @(negedge clk);
        bus.cp_clr_cmd_rdy = 0;
        wait_for(3, WD_MAX + 10, n);
        chk("t5_nak", 32'(bus.tc_nak), 1);
        @(negedge clk);

        // Timeout while still in ISSUE: 256 cycles from grant
        bus.rmt_cmd_rdy = 1;
        wait_for(0, 10, n);
        bus.rmt_cmd_rdy = 0;
        wait_for(2, WD_MAX + 10, n);
        chk("t6_cycles", 32'(n), 32'd256);
        chk("t6_tx", 32'(bus.tx_data), 32'h5A);
        @(negedge clk);

        // Completion in the saturation cycle wins
        bus.rmt_cmd_rdy = 1;
        wait_for(0, 10, n);
        bus.rmt_cmd_rdy = 0;
        bus.cp_clr_cmd_rdy = 1;
        @(negedge clk);
        bus.cp_clr_cmd_rdy = 0;
        repeat (WD_MAX - 1) @(negedge clk);
        bus.cp_send_resp = 1;
        @(negedge clk);
        bus.cp_send_resp = 0;
        chk("t7_trmt", 32'(bus.trmt), 1);
        chk("t7_tx", 32'(bus.tx_data), 32'hA5);
        @(negedge clk);

        // Reset mid-EXEC with the remote request still held
        bus.rmt_cmd_rdy = 1;
        wait_for(0, 10, n);
        bus.cp_clr_cmd_rdy = 1;
        @(negedge clk);
        bus.cp_clr_cmd_rdy = 0;
        repeat (10) @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("t8_busy", 32'(bus.busy), 0);
        chk("t8_cmd", 32'(bus.cmd), 0);
        chk("t8_trmt", 32'(bus.trmt), 0);
        rst_n = 1;
        @(negedge clk);
        chk("t8_regrant", 32'(bus.rmt_clr_cmd_rdy), 1);
        chk("t8_cmd_rdy", 32'(bus.cmd_rdy), 1);
        chk("t8_regrant_cmd", 32'(bus.cmd), 32'h4BF4);
        bus.rmt_cmd_rdy = 0;
        serve(4);
        chk("t8_tx", 32'(bus.tx_data), 32'hA5);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmd_arbiter.md
Name: cmd_arbiter

Overview:
- Shares the single cmd_proc command port between two requesters: remote UART commands (UART_wrapper) and autonomous tour commands (TourCmd).
- Grants one requester at a time and presents its 16-bit command with a level cmd_rdy / clr_cmd_rdy handshake.
- Holds the grant until cmd_proc signals completion (send_resp), then routes the result to the owner: an ACK/NAK byte to the UART for remote, or a done/nak pulse for tour.
- A watchdog aborts hung commands.

Parameters:
- FAST_SIM, 1: selects the watchdog length. 1 gives a 2^16-cycle timeout; 0 gives a 2^26-cycle timeout.
- ACK, 8'hA5: byte sent to the UART on successful completion.
- NAK, 8'h5A: byte sent to the UART on timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rmt_cmd  in  16  remote command, stable while rmt_cmd_rdy is high
- rmt_cmd_rdy  in  1  remote request (level)
- rmt_clr_cmd_rdy  out  1  one-cycle pulse: remote command accepted
- tc_cmd  in  16  tour command
- tc_cmd_rdy  in  1  tour request (level)
- tc_clr_cmd_rdy  out  1  one-cycle pulse: tour command accepted
- cmd  out  16  granted command to cmd_proc
- cmd_rdy  out  1  command valid to cmd_proc
- cp_clr_cmd_rdy  in  1  cmd_proc consumed the command
- cp_send_resp  in  1  cmd_proc completion pulse
- tx_data  out  8  response byte to UART
- trmt  out  1  one-cycle UART transmit strobe
- tc_done  out  1  one-cycle pulse: tour command finished
- tc_nak  out  1  qualifies tc_done: 1 = timed out
- owner  out  1  current or last grant: 0 = remote, 1 = tour
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state = IDLE. cmd = 0, owner = 0, tx_data = 0. All strobes, cmd_rdy, busy and tc_nak = 0. Watchdog counter cleared.
- All outputs are registered.
- Reset mid-operation:
  - The grant is dropped and no response is emitted.
  - Requesters still hold their rdy lines, so their commands are re-arbitrated after reset.
- IDLE:
  - If any rdy is sampled high at edge k, the winner is chosen by policy.
  - At k+1: cmd = winner's command, owner = winner, cmd_rdy = 1, and the winner's clr pulse is high for exactly that one cycle. State goes to ISSUE.
  - The loser's rdy is untouched.
- Default policy: fixed priority, remote over tour.
- ISSUE:
  - cmd_rdy is held high and the watchdog runs.
  - On cp_clr_cmd_rdy: cmd_rdy = 0 next cycle, state goes to EXEC.
  - cp_send_resp arriving in ISSUE is ignored.
- EXEC:
  - The watchdog keeps counting.
  - On cp_send_resp: go to RESP with result = ACK.
  - On watchdog saturation (all ones): go to RESP with result = NAK.
  - If both occur in the same cycle, ACK wins.
- Timeout in ISSUE: cmd_rdy drops, go to RESP with result = NAK.
- RESP (exactly one cycle):
  - owner = 0: trmt = 1, tx_data = ACK or NAK.
  - owner = 1: tc_done = 1, tc_nak = (result == NAK).
  - Then IDLE. The watchdog is cleared on entry to IDLE.
- New requests are never sampled outside IDLE. Minimum spacing between grants is 4 cycles.
- cmd keeps its last value after completion; only cmd_rdy qualifies it.
- Watchdog width: 16 bits (FAST_SIM = 1) or 26 bits (FAST_SIM = 0). It does not wrap; saturation is the timeout event.

Optional Feature:
- Macro: CMD_ARB_RR_EN.
- Defined: round-robin arbitration. A last_owner flop (reset = 1, so remote wins the first tie) gives a tie to the requester not served last. A single requester is always granted.
- Undefined: fixed remote-over-tour priority and no last_owner flop.

Decomposition:
- Package kt_arb_pkg:
  - state_t enum {IDLE, ISSUE, EXEC, RESP}
  - owner_t enum {OWN_RMT, OWN_TC}
  - ACK_BYTE, NAK_BYTE constants
  - watchdog width function of FAST_SIM
- Sub-module cmd_wdog: clear/enable counter with saturating timeout output, width parameterised.

Test Plan:
- Remote only: rmt_cmd = 16'h4BF4, rdy high.
  - Next cycle: cmd = 16'h4BF4, cmd_rdy = 1, single-cycle rmt_clr_cmd_rdy.
  - cp_clr_cmd_rdy, then cp_send_resp 100 cycles later.
  - Expect trmt pulse with tx_data = 8'hA5, busy low afterwards.
- Tour only: tc_cmd = 16'h4002.
  - Completion gives tc_done = 1, tc_nak = 0.
  - No trmt ever.
- Simultaneous requests: rmt = 16'h4BF4, tc = 16'h43F1.
  - Default build: remote is granted first, tour on the next IDLE.
  - With CMD_ARB_RR_EN: after a remote grant, the next tie goes to tour.
- Timeout: FAST_SIM = 1, remote command consumed, cp_send_resp withheld.
  - After 65535 EXEC cycles: trmt with tx_data = 8'h5A.
  - Tour variant: tc_done = 1, tc_nak = 1.
- Race: cp_send_resp asserted in the same cycle the watchdog saturates → ACK 8'hA5.
- Reset mid-EXEC: rst_n low for 2 cycles.
  - All outputs return to 0, no trmt.
  - The still-held rmt_cmd_rdy is re-granted 1 cycle after reset release.
